// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter (start, LSB-first data, optional parity, one stop bit).
module uart_tx_fifo #(
  parameter int CLK_FRE     = 50,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst_n,
  input  logic [DATA_WIDTH-1:0]         i_data_tx,
  input  logic                          i_data_valid,
  output logic                          o_data_ready,
  output logic                          o_uart_tx,
  output logic                          o_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);
  localparam int DIV = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int IW  = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [AW:0]           r_count;
  logic [2:0]            r_state;
  logic [CW-1:0]         r_div;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par, r_tx, r_ovf;
  logic                  w_push, w_pop, w_tick, w_par;
  logic [DATA_WIDTH-1:0] w_head, w_shift_nx;

  assign w_head       = r_mem[r_rptr];
  assign w_par        = ^w_head ^ (PARITY_TYPE != 0);
  assign o_data_ready = r_count != (AW+1)'(FIFO_DEPTH);
  assign w_push       = i_data_valid && o_data_ready;
  assign w_tick       = r_div == CW'(DIV - 1);
  // Pop when idle, or exactly as a stop bit ends so the next start follows with no gap
  assign w_pop        = r_count != '0 && (r_state == S_IDLE || (r_state == S_STOP && w_tick));
  assign w_shift_nx   = r_shift >> 1;
  assign o_uart_tx    = r_tx;
  assign o_tx_busy    = r_state != S_IDLE;
  assign o_fifo_count = r_count;
  assign o_overflow   = r_ovf;

  always_ff @(posedge i_clk_sys)
    if (w_push) r_mem[r_wptr] <= i_data_tx;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push != w_pop) r_count <= w_push ? r_count + (AW+1)'(1) : r_count - (AW+1)'(1);
      r_ovf <= i_data_valid && !o_data_ready;
    end
  end

  // Line value is registered from the next state so it changes on the same edge as the state
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_div <= (r_state == S_IDLE || w_tick) ? '0 : r_div + CW'(1);
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= w_par;
      end
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_state <= S_START;
          r_tx    <= 1'b0;
        end
        S_START: if (w_tick) begin
          r_state <= S_DATA;
          r_idx   <= '0;
          r_tx    <= r_shift[0];
        end
        S_DATA: if (w_tick) begin
          if (r_idx == IW'(DATA_WIDTH - 1)) begin
            r_state <= PARITY_ON != 0 ? S_PARITY : S_STOP;
            r_tx    <= PARITY_ON != 0 ? r_par : 1'b1;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_shift <= w_shift_nx;
            r_tx    <= w_shift_nx[0];
          end
        end
        S_PARITY: if (w_tick) begin
          r_state <= S_STOP;
          r_tx    <= 1'b1;
        end
        S_STOP: if (w_tick) begin
          r_state <= w_pop ? S_START : S_IDLE;
          r_tx    <= !w_pop;
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at DIV = 8 with no-parity, even and odd instances.
module tb_uart_tx_fifo;
  localparam int DIV = 8;
  logic       clk, rst_n, valid;
  logic [7:0] data;
  logic       rdy_n, tx_n, busy_n, ovf_n;
  logic       rdy_e, tx_e, busy_e, ovf_e;
  logic       rdy_o, tx_o, busy_o, ovf_o;
  logic [4:0] cnt_n, cnt_e, cnt_o;
  int         n_vec = 0, n_err = 0;

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(125000), .PARITY_ON(0)) dut_n (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data_tx(data), .i_data_valid(valid),
    .o_data_ready(rdy_n), .o_uart_tx(tx_n), .o_tx_busy(busy_n), .o_fifo_count(cnt_n), .o_overflow(ovf_n));
  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(125000), .PARITY_ON(1), .PARITY_TYPE(0)) dut_e (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data_tx(data), .i_data_valid(valid),
    .o_data_ready(rdy_e), .o_uart_tx(tx_e), .o_tx_busy(busy_e), .o_fifo_count(cnt_e), .o_overflow(ovf_e));
  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(125000), .PARITY_ON(1), .PARITY_TYPE(1)) dut_o (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data_tx(data), .i_data_valid(valid),
    .o_data_ready(rdy_o), .o_uart_tx(tx_o), .o_tx_busy(busy_o), .o_fifo_count(cnt_o), .o_overflow(ovf_o));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return sel == 0 ? tx_n : sel == 1 ? tx_e : tx_o;
  endfunction

  function automatic logic busy(input int sel);
    return sel == 0 ? busy_n : sel == 1 ? busy_e : busy_o;
  endfunction

  task automatic put(input logic [7:0] d);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
  endtask

  // Receiver model: gap = negedges waited for the start bit (-1 on timeout), then mid-bit samples
  task automatic rx(input int sel, input bit par, input int limit, output logic [7:0] d,
                    output logic p, output logic st, output logic sp, output int gap);
    gap = 0; d = '0; p = 1'b0; st = 1'b1; sp = 1'b0;
    while (line(sel) !== 1'b0 && gap < limit) begin
      @(negedge clk);
      gap++;
    end
    if (line(sel) !== 1'b0) begin
      gap = -1;
      return;
    end
    repeat (DIV / 2) @(negedge clk);
    st = line(sel);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      d[i] = line(sel);
    end
    if (par) begin
      repeat (DIV) @(negedge clk);
      p = line(sel);
    end
    repeat (DIV) @(negedge clk);
    sp = line(sel);
  endtask

  task automatic busy_len(input int sel, output int n);
    n = 0;
    while (busy(sel) === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  logic [7:0] d0, d1, d2;
  logic       p0, p1, p2, s0, s1, s2, e0, e1, e2;
  int         g0, g1, g2, bl;
  bit         bad;

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_n, 1);
    chk("rst_busy", busy_n, 0);
    chk("rst_count", cnt_n, 0);
    chk("rst_ready", rdy_n, 1);
    chk("rst_ovf", ovf_n, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20000) begin
      @(negedge clk);
      if (tx_n !== 1 || busy_n !== 0 || cnt_n !== 0 || rdy_n !== 1) bad = 1;
    end
    chk("idle_20000", bad, 0);

    put(8'h55);
    valid = 1'b0;
    chk("single_count_after_accept", cnt_n, 1);
    chk("single_line_before_E1", tx_n, 1);
    @(negedge clk);
    chk("single_line_fall", tx_n, 0);
    chk("single_busy_rise", busy_n, 1);
    chk("single_count_popped", cnt_n, 0);
    fork
      rx(0, 0, 100, d0, p0, s0, e0, g0);
      busy_len(0, bl);
    join
    chk("single_start", s0, 0);
    chk("single_data", d0, 8'h55);
    chk("single_stop", e0, 1);
    chk("single_busy_len", bl, 10 * DIV);
    repeat (100) @(negedge clk);

    put(8'hA7);
    valid = 1'b0;
    @(negedge clk);
    fork
      rx(1, 1, 100, d1, p1, s1, e1, g1);
      rx(2, 1, 100, d2, p2, s2, e2, g2);
      rx(0, 0, 100, d0, p0, s0, e0, g0);
      busy_len(1, bl);
    join
    chk("even_data", d1, 8'hA7);
    chk("even_parity", p1, 1);
    chk("even_stop", e1, 1);
    chk("odd_data", d2, 8'hA7);
    chk("odd_parity", p2, 0);
    chk("odd_stop", e2, 1);
    chk("nopar_data", d0, 8'hA7);
    chk("nopar_stop", e0, 1);
    chk("parity_busy_len", bl, 11 * DIV);
    repeat (100) @(negedge clk);

    fork
      begin
        for (int i = 0; i < 17; i++) put(i[7:0]);
        chk("burst_full_count", cnt_n, 16);
        chk("burst_full_ready", rdy_n, 0);
        put(8'hEE);
        valid = 1'b0;
        chk("burst_ovf_pulse", ovf_n, 1);
        chk("burst_count_kept", cnt_n, 16);
        @(negedge clk);
        chk("burst_ovf_one_cycle", ovf_n, 0);
      end
      begin
        for (int i = 0; i < 17; i++) begin
          rx(0, 0, 3000, d0, p0, s0, e0, g0);
          chk($sformatf("burst_data_%0d", i), d0, i);
          chk($sformatf("burst_stop_%0d", i), e0, 1);
          if (i > 0) chk($sformatf("burst_gap_%0d", i), g0, DIV / 2);
        end
      end
    join
    rx(0, 0, 200, d0, p0, s0, e0, g0);
    chk("burst_no_dropped_word", g0 == -1, 1);
    chk("burst_idle_busy", busy_n, 0);
    chk("burst_idle_count", cnt_n, 0);

    fork
      begin
        put(8'hA0); put(8'hA1); put(8'hA2); put(8'hA3);
        valid = 1'b0;
        repeat (10 * DIV - 3) @(negedge clk);
        chk("pushpop_count_before", cnt_n, 3);
        chk("pushpop_in_stop", tx_n, 1);
        put(8'hA4);
        valid = 1'b0;
        chk("pushpop_count_after", cnt_n, 3);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx(0, 0, 3000, d0, p0, s0, e0, g0);
          chk($sformatf("pushpop_data_%0d", i), d0, 8'hA0 + i);
          if (i > 0) chk($sformatf("pushpop_gap_%0d", i), g0, DIV / 2);
        end
      end
    join
    repeat (200) @(negedge clk);

    for (int i = 0; i < 6; i++) put(i[7:0]);
    valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_bit4_line", tx_n, 0);
    chk("midrst_busy_before", busy_n, 1);
    chk("midrst_count_before", cnt_n, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_line_async", tx_n, 1);
    chk("midrst_busy_async", busy_n, 0);
    chk("midrst_count_async", cnt_n, 0);
    chk("midrst_ready_async", rdy_n, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_n !== 1 || busy_n !== 0 || cnt_n !== 0) bad = 1;
    end
    chk("midrst_stays_idle", bad, 0);
    put(8'h3C);
    valid = 1'b0;
    rx(0, 0, 100, d0, p0, s0, e0, g0);
    chk("postrst_latency", g0, 1);
    chk("postrst_data", d0, 8'h3C);
    chk("postrst_stop", e0, 1);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
